flash_wb_byte_writer: RTL and testbench

Wishbone classic slave that accepts 32-bit write cycles and serialises each enabled byte lane into a timed byte write on an 8-bit parallel memory/flash port (setup, write pulse, hold). It is the write-direction companion to the byte-serial boot-ROM reader on the OR1K startup path. It sits on the same 32-word window, addressed by `wb_adr_i[4:0]`, with the same byte-to-lane mapping.

---
 rtl/flash_wb_pkg.sv | 26 ++
 rtl/flash_wb_byte_writer_sel_scan.sv | 29 ++
 rtl/flash_wb_byte_writer.sv | 203 ++++++++++++++++++++
 tb/tb_flash_wb_byte_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_wb_pkg.sv
// flash_wb_pkg
//   Types and constants shared by the byte-serial flash/boot-ROM reader and
//   writer on the 32-word Wishbone window.
//   - state_e    : writer FSM states
//   - PHASE_W    : width of the per-phase cycle counter (covers 1..15)
//   - LANES      : byte lanes per 32-bit Wishbone word
//   - byte_lane(): pick byte lane k out of a 32-bit word (lane k = bits 8k+7:8k)
package flash_wb_pkg;

  localparam int PHASE_W = 4;
  localparam int LANES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ACK   = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/flash_wb_byte_writer_sel_scan.sv
// wb_sel_scan
//   Combinational search for the lowest enabled byte lane strictly above a
//   given lane index.
//   - sel_i   : byte-lane enables
//   - lane_i  : current lane; only lanes above it are considered
//   - found_o : an enabled lane above lane_i exists
//   - next_o  : that lane (equals lane_i when none is found)
module wb_sel_scan
  import flash_wb_pkg::*;
(
  input  logic [LANES-1:0] sel_i,
  input  logic [1:0]       lane_i,
  output logic             found_o,
  output logic [1:0]       next_o
);

  // Scan from the top down so the last hit is the lowest qualifying lane.
  always_comb begin
    found_o = 1'b0;
    next_o  = lane_i;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (sel_i[k] && (k > int'(lane_i))) begin
        found_o = 1'b1;
        next_o  = 2'(k);
      end
    end
  end

endmodule

// File: rtl/flash_wb_byte_writer.sv
// flash_wb_byte_writer
//   Wishbone classic write slave that serialises each enabled byte lane of a
//   32-bit write into a timed byte write (setup, write pulse, hold) on an
//   8-bit parallel memory/flash port. Read cycles are answered with err.
//   Ports:
//   - clk, rst_n            : clock, asynchronous active-low reset
//   - wb_adr_i[4:0]         : word address in the 32-word window
//   - wb_dat_i/sel_i/we_i   : write data, byte enables, write enable
//   - wb_cyc_i/stb_i        : cycle / strobe
//   - wb_ack_o / wb_err_o   : one-cycle write ack / read error
//   - mem_addr_o[6:0]       : byte address {word_addr, lane}
//   - mem_dat_o[7:0]        : byte data
//   - mem_we_o              : active-high write pulse
//   - busy_o                : request accepted and not yet finished
module flash_wb_byte_writer
  import flash_wb_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [6:0]  mem_addr_o,
  output logic [7:0]  mem_dat_o,
  output logic        mem_we_o,
  output logic        busy_o
);

  localparam logic [PHASE_W-1:0] SETUP_LD = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0] PULSE_LD = PHASE_W'(PULSE_CYC - 1);
  localparam logic [PHASE_W-1:0] HOLD_LD  = PHASE_W'(HOLD_CYC - 1);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic [4:0]         adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic [1:0]         lane_q, lane_d;
  logic               abort_q, abort_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic [6:0]         maddr_q, maddr_d;
  logic [7:0]         mdat_q, mdat_d;

  // One scanner serves both lookups: in IDLE it searches the live select
  // above lane 0, in HOLD it searches the latched select above the current lane.
  logic       idle_sel;
  logic [3:0] scan_sel;
  logic [1:0] scan_lane;
  logic       scan_found;
  logic [1:0] scan_next;
  logic [1:0] first_lane;
  logic       abort_now;

  assign idle_sel  = (state_q == ST_IDLE);
  assign scan_sel  = idle_sel ? wb_sel_i : sel_q;
  assign scan_lane = idle_sel ? 2'd0 : lane_q;

  wb_sel_scan u_scan (
    .sel_i   (scan_sel),
    .lane_i  (scan_lane),
    .found_o (scan_found),
    .next_o  (scan_next)
  );

  assign first_lane = wb_sel_i[0] ? 2'd0 : scan_next;
  // A dropped cyc is remembered until the current byte has finished its hold.
  assign abort_now  = abort_q | ~wb_cyc_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    lane_d  = lane_q;
    abort_d = abort_q;
    maddr_d = maddr_q;
    mdat_d  = mdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    we_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          dat_d   = wb_dat_i;
          sel_d   = wb_sel_i;
          abort_d = 1'b0;
          if (!wb_we_i) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (wb_sel_i == 4'b0000) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            lane_d  = first_lane;
            maddr_d = {wb_adr_i, first_lane};
            mdat_d  = byte_lane(wb_dat_i, first_lane);
          end
        end
      end
      ST_SETUP: begin
        abort_d = abort_now;
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        abort_d = abort_now;
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
          we_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        abort_d = abort_now;
        if (cnt_q == '0) begin
          if (abort_now) begin
            state_d = ST_IDLE;
          end else if (scan_found) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            lane_d  = scan_next;
            maddr_d = {adr_q, scan_next};
            mdat_d  = byte_lane(dat_q, scan_next);
          end else begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      lane_q  <= '0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      maddr_q <= '0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      lane_q  <= lane_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      maddr_q <= maddr_d;
      mdat_q  <= mdat_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign mem_we_o   = we_q;
  assign busy_o     = busy_q;
  assign mem_addr_o = maddr_q;
  assign mem_dat_o  = mdat_q;

endmodule

// File: tb/tb_flash_wb_byte_writer.sv
// tb_flash_wb_byte_writer
//   Directed bench for flash_wb_byte_writer. Instance a uses the default
//   timing, instance b uses SETUP=3/PULSE=15/HOLD=2. Each scenario task
//   drives a request, records the memory-port activity cycle by cycle and
//   compares against hand-computed values.
module tb_flash_wb_byte_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        cyc_a = 1'b0;
  logic        cyc_b = 1'b0;

  logic       a_ack, a_err, a_we, a_busy;
  logic [6:0] a_addr;
  logic [7:0] a_dat;
  logic       b_ack, b_err, b_we, b_busy;
  logic [6:0] b_addr;
  logic [7:0] b_dat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flash_wb_byte_writer u_dut_a (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(cyc_a), .wb_stb_i(wb_stb), .wb_ack_o(a_ack), .wb_err_o(a_err),
    .mem_addr_o(a_addr), .mem_dat_o(a_dat), .mem_we_o(a_we), .busy_o(a_busy)
  );

  flash_wb_byte_writer #(.SETUP_CYC(3), .PULSE_CYC(15), .HOLD_CYC(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(cyc_b), .wb_stb_i(wb_stb), .wb_ack_o(b_ack), .wb_err_o(b_err),
    .mem_addr_o(b_addr), .mem_dat_o(b_dat), .mem_we_o(b_we), .busy_o(b_busy)
  );

  // Observations of the most recent transaction
  int         n_wr, ack_cyc, err_cyc, ack_cnt, err_cnt, both_cnt;
  int         busy_first, busy_fall, first_rise, last_fall;
  logic [6:0] wr_addr [8];
  logic [7:0] wr_dat  [8];
  int         wr_len  [8];
  logic [6:0] end_addr;
  logic [7:0] end_dat;

  // Issue one request (cycle 0 = edge that samples it) and record ncyc cycles.
  // abort_t > 0 drops cyc in that cycle.
  task automatic run_txn(input bit use_b, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input int abort_t, input int ncyc);
    logic       o_we, o_ack, o_err, o_busy, prev_we;
    logic [6:0] o_addr;
    logic [7:0] o_dat;
    int         plen;
    n_wr = 0; ack_cyc = -1; err_cyc = -1; ack_cnt = 0; err_cnt = 0; both_cnt = 0;
    busy_first = -1; busy_fall = -1; first_rise = -1; last_fall = -1;
    for (int i = 0; i < 8; i++) begin
      wr_addr[i] = '0; wr_dat[i] = '0; wr_len[i] = 0;
    end
    @(negedge clk);
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_stb = 1'b1;
    if (use_b) cyc_b = 1'b1; else cyc_a = 1'b1;
    prev_we = 1'b0;
    plen = 0;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      o_we   = use_b ? b_we   : a_we;
      o_ack  = use_b ? b_ack  : a_ack;
      o_err  = use_b ? b_err  : a_err;
      o_busy = use_b ? b_busy : a_busy;
      o_addr = use_b ? b_addr : a_addr;
      o_dat  = use_b ? b_dat  : a_dat;
      if (o_we) begin
        if (!prev_we && n_wr < 8) begin
          wr_addr[n_wr] = o_addr;
          wr_dat[n_wr]  = o_dat;
          if (first_rise < 0) first_rise = t;
          plen = 0;
        end
        plen++;
      end else if (prev_we && n_wr < 8) begin
        wr_len[n_wr] = plen;
        n_wr++;
        last_fall = t;
      end
      prev_we = o_we;
      if (o_ack) begin ack_cnt++; if (ack_cyc < 0) ack_cyc = t; end
      if (o_err) begin err_cnt++; if (err_cyc < 0) err_cyc = t; end
      if (o_ack && o_err) both_cnt++;
      if (o_busy && busy_first < 0) busy_first = t;
      if (!o_busy && busy_first > 0 && busy_fall < 0) busy_fall = t;
      if (o_ack || o_err || t == abort_t) begin
        wb_stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
      end
      end_addr = o_addr;
      end_dat  = o_dat;
    end
    wb_stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({a_ack, a_err, a_we, a_busy, a_addr, a_dat} !== 19'd0) begin
      n_bad++; $display("FAIL reset_a: got %0h want 0", {a_ack, a_err, a_we, a_busy, a_addr, a_dat});
    end
    n_cmp++;
    if ({b_ack, b_err, b_we, b_busy, b_addr, b_dat} !== 19'd0) begin
      n_bad++; $display("FAIL reset_b: got %0h want 0", {b_ack, b_err, b_we, b_busy, b_addr, b_dat});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic check_full_word(input string tag);
    logic [6:0] ea [4];
    logic [7:0] ed [4];
    ea = '{7'h14, 7'h15, 7'h16, 7'h17};
    ed = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    n_cmp++;
    if (n_wr !== 4) begin n_bad++; $display("FAIL %s_nwr: got %0d want 4", tag, n_wr); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wr_addr[i] !== ea[i] || wr_dat[i] !== ed[i] || wr_len[i] !== 2) begin
        n_bad++;
        $display("FAIL %s_wr%0d: got (%0h,%0h,len %0d) want (%0h,%0h,len 2)",
                 tag, i, wr_addr[i], wr_dat[i], wr_len[i], ea[i], ed[i]);
      end
    end
    n_cmp++;
    if (ack_cyc !== 17 || ack_cnt !== 1) begin
      n_bad++; $display("FAIL %s_ack: got cyc %0d cnt %0d want cyc 17 cnt 1", tag, ack_cyc, ack_cnt);
    end
    n_cmp++;
    if (busy_first !== 1 || busy_fall !== 18) begin
      n_bad++; $display("FAIL %s_busy: got %0d..%0d want 1..18", tag, busy_first, busy_fall);
    end
  endtask

  task automatic test_full_word();
    run_txn(1'b0, 5'd5, 32'hA1B2C3D4, 4'b1111, 1'b1, 0, 22);
    check_full_word("full");
    n_cmp++;
    if (first_rise !== 2 || err_cnt !== 0 || both_cnt !== 0) begin
      n_bad++; $display("FAIL full_misc: got rise %0d err %0d both %0d want 2 0 0", first_rise, err_cnt, both_cnt);
    end
    n_cmp++;
    if (end_addr !== 7'h17 || end_dat !== 8'hA1) begin
      n_bad++; $display("FAIL full_idle_hold: got (%0h,%0h) want (17,a1)", end_addr, end_dat);
    end
    $display("test_full_word: %0d writes, ack cycle %0d", n_wr, ack_cyc);
  endtask

  task automatic test_sparse();
    run_txn(1'b0, 5'd0, 32'h11223344, 4'b1010, 1'b1, 0, 14);
    n_cmp++;
    if (n_wr !== 2 || wr_addr[0] !== 7'h01 || wr_dat[0] !== 8'h33 || wr_addr[1] !== 7'h03 || wr_dat[1] !== 8'h11) begin
      n_bad++;
      $display("FAIL sparse_writes: got %0d (%0h,%0h) (%0h,%0h) want 2 (1,33) (3,11)",
               n_wr, wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]);
    end
    n_cmp++;
    if (ack_cyc !== 9 || ack_cnt !== 1) begin
      n_bad++; $display("FAIL sparse_ack: got cyc %0d cnt %0d want 9 1", ack_cyc, ack_cnt);
    end
    $display("test_sparse: %0d writes, ack cycle %0d", n_wr, ack_cyc);
  endtask

  task automatic test_zero_sel();
    run_txn(1'b0, 5'd9, 32'hFFFFFFFF, 4'b0000, 1'b1, 0, 6);
    n_cmp++;
    if (ack_cyc !== 1 || ack_cnt !== 1 || err_cnt !== 0 || n_wr !== 0 || first_rise !== -1) begin
      n_bad++; $display("FAIL zero_sel: got ack %0d cnt %0d err %0d wr %0d want 1 1 0 0", ack_cyc, ack_cnt, err_cnt, n_wr);
    end
    n_cmp++;
    if (end_addr !== 7'h03 || end_dat !== 8'h11 || busy_fall !== 2) begin
      n_bad++; $display("FAIL zero_sel_port: got (%0h,%0h) busy_fall %0d want (3,11) 2", end_addr, end_dat, busy_fall);
    end
    $display("test_zero_sel: ack cycle %0d", ack_cyc);
  endtask

  task automatic test_read_err();
    run_txn(1'b0, 5'd7, 32'h55AA55AA, 4'b1111, 1'b0, 0, 6);
    n_cmp++;
    if (err_cyc !== 1 || err_cnt !== 1 || ack_cnt !== 0 || n_wr !== 0 || first_rise !== -1) begin
      n_bad++; $display("FAIL read_err: got err %0d cnt %0d ack %0d wr %0d want 1 1 0 0", err_cyc, err_cnt, ack_cnt, n_wr);
    end
    n_cmp++;
    if (end_addr !== 7'h03 || end_dat !== 8'h11) begin
      n_bad++; $display("FAIL read_err_port: got (%0h,%0h) want (3,11)", end_addr, end_dat);
    end
    $display("test_read_err: err cycle %0d", err_cyc);
  endtask

  task automatic test_abort();
    // Lane 1 pulses in cycles 6-7; cyc drops in cycle 6.
    run_txn(1'b0, 5'd5, 32'hA1B2C3D4, 4'b1111, 1'b1, 6, 20);
    n_cmp++;
    if (n_wr !== 2 || wr_addr[1] !== 7'h15 || wr_dat[1] !== 8'hC3 || wr_len[1] !== 2) begin
      n_bad++; $display("FAIL abort_writes: got %0d (%0h,%0h,len %0d) want 2 (15,c3,len 2)",
                        n_wr, wr_addr[1], wr_dat[1], wr_len[1]);
    end
    n_cmp++;
    if (ack_cnt !== 0 || err_cnt !== 0 || busy_fall !== 9) begin
      n_bad++; $display("FAIL abort_end: got ack %0d err %0d busy_fall %0d want 0 0 9", ack_cnt, err_cnt, busy_fall);
    end
    $display("test_abort: %0d writes, busy fell at cycle %0d", n_wr, busy_fall);
  endtask

  task automatic test_reset_mid_pulse();
    @(negedge clk);
    wb_adr = 5'd5; wb_dat = 32'hA1B2C3D4; wb_sel = 4'b1111; wb_we = 1'b1; wb_stb = 1'b1; cyc_a = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (a_we !== 1'b1) begin n_bad++; $display("FAIL rst_pre_pulse: got we %0b want 1", a_we); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_ack, a_err, a_we, a_busy, a_addr, a_dat} !== 19'd0) begin
      n_bad++; $display("FAIL rst_async: got %0h want 0", {a_ack, a_err, a_we, a_busy, a_addr, a_dat});
    end
    @(negedge clk);
    wb_stb = 1'b0; cyc_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 5'd5, 32'hA1B2C3D4, 4'b1111, 1'b1, 0, 22);
    check_full_word("after_rst");
    $display("test_reset_mid_pulse: %0d writes after reset, ack cycle %0d", n_wr, ack_cyc);
  endtask

  task automatic test_params();
    run_txn(1'b1, 5'd3, 32'h00EE0000, 4'b0100, 1'b1, 0, 26);
    n_cmp++;
    if (n_wr !== 1 || wr_addr[0] !== 7'h0E || wr_dat[0] !== 8'hEE) begin
      n_bad++; $display("FAIL param_write: got %0d (%0h,%0h) want 1 (e,ee)", n_wr, wr_addr[0], wr_dat[0]);
    end
    n_cmp++;
    if (first_rise - 1 !== 3 || wr_len[0] !== 15 || ack_cyc - last_fall !== 2) begin
      n_bad++; $display("FAIL param_phases: got %0d/%0d/%0d want 3/15/2", first_rise - 1, wr_len[0], ack_cyc - last_fall);
    end
    n_cmp++;
    if (ack_cyc !== 21 || ack_cnt !== 1) begin
      n_bad++; $display("FAIL param_ack: got cyc %0d cnt %0d want 21 1", ack_cyc, ack_cnt);
    end
    $display("test_params: pulse %0d cycles, ack cycle %0d", wr_len[0], ack_cyc);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_sparse();
    test_zero_sel();
    test_read_err();
    test_abort();
    test_reset_mid_pulse();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
